// File: rtl/cobs_pkg.sv
// Shared types and constants for the COBS framing encoder.
package cobs_pkg;
  localparam int         COBS_MAX_BLOCK = 254;
  localparam logic [7:0] COBS_DELIM     = 8'h00;

  typedef enum logic [2:0] {
    ACCUM,
    EMIT_CODE,
    EMIT_DATA,
    EMIT_TAIL,
    EMIT_DELIM
  } cobs_enc_state_t;
endpackage

// File: rtl/axis_interface.sv
// Minimal AXI-Stream bundle with source/sink views.
interface axis_interface #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport Source (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
  modport Sink   (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_byte_serializer.sv
// Unpacks AXI-Stream beats into one byte per cycle, low byte first.
// COBS_ENC_TKEEP_EN: honour tkeep (null bytes skipped, empty tlast beat = end marker).
module axis_byte_serializer #(
  parameter int DATA_W = 16,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_tdata,
  input  logic [KEEP_W-1:0] i_tkeep,
  input  logic              i_tvalid,
  input  logic              i_tlast,
  output logic              o_tready,
  input  logic              i_en,
  input  logic              i_take,
  output logic              o_vld,
  output logic [7:0]        o_data,
  output logic              o_last,
  output logic              o_eof
);
  logic [DATA_W-1:0] r_data;
  logic [KEEP_W-1:0] r_mask;
  logic              r_last;
  logic [KEEP_W-1:0] w_sel;
  logic [KEEP_W-1:0] w_keep;
  logic              w_final;
  logic              w_load;

`ifdef COBS_ENC_TKEEP_EN
  assign w_keep = i_tkeep;
`else
  logic w_unused_keep;
  assign w_unused_keep = ^i_tkeep;
  assign w_keep        = '1;
`endif

  // r_mask holds the bytes still to present; the lowest set bit goes next
  always_comb begin
    o_data = 8'h00;
    w_sel  = '0;
    for (int i = KEEP_W - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        o_data   = r_data[i*8 +: 8];
        w_sel    = '0;
        w_sel[i] = 1'b1;
      end
    end
  end

  assign w_final  = ((r_mask & (r_mask - KEEP_W'(1))) == '0);
  assign o_vld    = (|r_mask) || r_last;
  assign o_eof    = r_last && !(|r_mask);
  assign o_last   = r_last && w_final;
  assign o_tready = i_en && (!o_vld || (w_final && i_take));
  assign w_load   = i_tvalid && o_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_mask <= '0;
      r_last <= 1'b0;
    end else if (w_load) begin
      r_data <= i_tdata;
      r_mask <= w_keep;
      r_last <= i_tlast;
    end else if (i_take && o_vld) begin
      r_mask <= r_mask & ~w_sel;
      if (w_final) r_last <= 1'b0;
    end
  end
endmodule

// File: rtl/cobs_axis_stream_encoder.sv
// AXI-Stream packet -> delimited COBS byte stream, one frame per input packet.
// COBS_ENC_TKEEP_EN enables tkeep-aware unpacking in the serializer.
module cobs_axis_stream_encoder
  import cobs_pkg::*;
#(
  parameter int S_DATA_WIDTH = 16,
  parameter int S_KEEP_WIDTH = S_DATA_WIDTH / 8
) (
  input  logic          clk,
  input  logic          rst,
  axis_interface.Sink   original_data,
  axis_interface.Source encoded_data
);
  cobs_enc_state_t r_state, w_state_nxt, w_after;
  logic [7:0] r_count, r_code, r_rdptr;
  logic       r_tail, r_end, r_run;
  logic [7:0] r_buf [COBS_MAX_BLOCK];

  logic       w_en, w_take, w_bvld, w_blast, w_beof;
  logic [7:0] w_byte, w_cnt_inc;
  logic       w_stored, w_close, w_unused;

  assign w_unused = ^{original_data.tid, original_data.tdest, original_data.tuser};

  axis_byte_serializer #(.DATA_W(S_DATA_WIDTH), .KEEP_W(S_KEEP_WIDTH)) u_ser (
    .clk      (clk),
    .rst_n    (rst),
    .i_tdata  (original_data.tdata),
    .i_tkeep  (original_data.tkeep),
    .i_tvalid (original_data.tvalid),
    .i_tlast  (original_data.tlast),
    .o_tready (original_data.tready),
    .i_en     (w_en),
    .i_take   (w_take),
    .o_vld    (w_bvld),
    .o_data   (w_byte),
    .o_last   (w_blast),
    .o_eof    (w_beof)
  );

  // r_run keeps tready low until the first clock after reset release
  assign w_en      = r_run && (r_state == ACCUM);
  assign w_take    = w_en && w_bvld;
  assign w_stored  = w_take && !w_beof && (w_byte != 8'h00);
  assign w_cnt_inc = r_count + 8'd1;
  assign w_close   = w_take && (w_beof || w_blast || (w_byte == 8'h00) ||
                                (w_cnt_inc == 8'(COBS_MAX_BLOCK)));
  assign w_after   = r_tail ? EMIT_TAIL : (r_end ? EMIT_DELIM : ACCUM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ACCUM;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:      if (w_close) w_state_nxt = EMIT_CODE;
      EMIT_CODE:  if (encoded_data.tready) w_state_nxt = (r_code == 8'd1) ? w_after : EMIT_DATA;
      EMIT_DATA:  if (encoded_data.tready && (r_rdptr == r_code - 8'd2)) w_state_nxt = w_after;
      EMIT_TAIL:  if (encoded_data.tready) w_state_nxt = EMIT_DELIM;
      EMIT_DELIM: if (encoded_data.tready) w_state_nxt = ACCUM;
      default:    w_state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    encoded_data.tvalid = (r_state != ACCUM);
    encoded_data.tlast  = (r_state == EMIT_DELIM);
    encoded_data.tdata  = 8'h00;
    case (r_state)
      EMIT_CODE:  encoded_data.tdata = r_code;
      EMIT_DATA:  encoded_data.tdata = r_buf[r_rdptr];
      EMIT_TAIL:  encoded_data.tdata = 8'h01;
      EMIT_DELIM: encoded_data.tdata = COBS_DELIM;
      default:    encoded_data.tdata = 8'h00;
    endcase
  end

  assign encoded_data.tkeep = '1;
  assign encoded_data.tid   = '0;
  assign encoded_data.tdest = '0;
  assign encoded_data.tuser = '0;

  // Block bookkeeping: code is count+1 for zero/eof closes, count+2 when the
  // closing byte itself is stored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run   <= 1'b0;
      r_count <= 8'd0;
      r_code  <= 8'd0;
      r_rdptr <= 8'd0;
      r_tail  <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_close) begin
        r_count <= 8'd0;
        r_rdptr <= 8'd0;
        r_code  <= w_stored ? (w_cnt_inc + 8'd1) : w_cnt_inc;
        r_tail  <= !w_beof && (w_byte == 8'h00) && w_blast;
        r_end   <= w_blast || w_beof;
      end else if (w_stored) begin
        r_count <= w_cnt_inc;
      end
      if (r_state == EMIT_DATA && encoded_data.tready) r_rdptr <= r_rdptr + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_stored) r_buf[r_count] <= w_byte;
  end
endmodule

// File: tb/tb_cobs_axis_stream_encoder.sv
// Directed scoreboard bench for cobs_axis_stream_encoder (16-bit input).
module tb_cobs_axis_stream_encoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axis_interface #(.DATA_WIDTH(16)) s_if ();
  axis_interface #(.DATA_WIDTH(8))  m_if ();

  cobs_axis_stream_encoder #(.S_DATA_WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .original_data (s_if),
    .encoded_data  (m_if)
  );

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic       mon_en = 1'b0;
  int         rdy_mode = 0;   // 0 low, 1 high, 2 toggle
  logic       stalled = 1'b0;
  logic [8:0] stall_word;

  always begin
    m_if.tready = (rdy_mode == 2) ? ~m_if.tready : (rdy_mode == 1);
    @(posedge clk);
    #1;
  end

  always @(negedge clk) begin
    if (!mon_en) begin
      stalled = 1'b0;
    end else begin
      if (stalled && m_if.tvalid) begin
        checks++;
        assert ({m_if.tlast, m_if.tdata} === stall_word) else begin
          errors++;
          $error("FAIL stall_hold got %h exp %h", {m_if.tlast, m_if.tdata}, stall_word);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $error("FAIL unexpected_out got %h exp none", {m_if.tlast, m_if.tdata});
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          assert ({m_if.tlast, m_if.tdata} === e) else begin
            errors++;
            $error("FAIL out_byte got %h exp %h", {m_if.tlast, m_if.tdata}, e);
          end
        end
      end
      stalled    = m_if.tvalid && !m_if.tready;
      stall_word = {m_if.tlast, m_if.tdata};
    end
  end

  function automatic void emit_blk(input logic [7:0] blk[$]);
    exp_q.push_back({1'b0, 8'(blk.size() + 1)});
    foreach (blk[i]) exp_q.push_back({1'b0, blk[i]});
  endfunction

  // Reference COBS: 254-byte blocks close without an implied zero.
  function automatic void push_model(input logic [7:0] b[$]);
    logic [7:0] blk[$];
    foreach (b[i]) begin
      if (b[i] == 8'h00) begin
        emit_blk(blk);
        blk.delete();
      end else begin
        blk.push_back(b[i]);
        if (blk.size() == 254) begin
          emit_blk(blk);
          blk.delete();
        end
      end
    end
    if (blk.size() != 0 || b.size() == 0 || b[b.size()-1] == 8'h00) emit_blk(blk);
    exp_q.push_back({1'b1, 8'h00});
  endfunction

  task automatic send_beat(input logic [15:0] d, input logic [1:0] k, input logic l);
    logic hs;
    int   n;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      hs = s_if.tready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 2000);
    s_if.tvalid = 1'b0;
    checks++;
    assert (hs === 1'b1) else begin
      errors++;
      $error("FAIL in_handshake got %b exp 1", hs);
    end
  endtask

  task automatic send_frame(input logic [15:0] beats[$]);
    logic [7:0] bytes[$];
    foreach (beats[i]) begin
      bytes.push_back(beats[i][7:0]);
      bytes.push_back(beats[i][15:8]);
    end
    push_model(bytes);
    foreach (beats[i]) send_beat(beats[i], 2'b11, (i == beats.size() - 1));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() === 0) else begin
      errors++;
      $error("FAIL drain_%s got %0d left exp 0", tag, exp_q.size());
    end
  endtask

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, want);
    end
  endtask

  initial begin
    logic [15:0] bq[$];
    logic [7:0]  bb[$];
    int          lat, n;

    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
    s_if.tid = '0; s_if.tdest = '0; s_if.tuser = '0;

    repeat (3) @(negedge clk);
    chk("rst_in_tready", 9'(s_if.tready), 9'h0);
    chk("rst_tvalid",    9'(m_if.tvalid), 9'h0);
    chk("rst_tdata",     9'(m_if.tdata),  9'h0);
    chk("rst_tlast",     9'(m_if.tlast),  9'h0);
    rst = 1'b1;
    #1 chk("tready_before_edge", 9'(s_if.tready), 9'h0);
    @(posedge clk); #1;
    chk("tready_after_edge", 9'(s_if.tready), 9'h1);

    mon_en = 1'b1;
    rdy_mode = 1;

    // basic frame + latency (handshake cycle is cycle 0)
    bb.delete(); bb.push_back(8'h71); bb.push_back(8'h69);
    push_model(bb);
    send_beat(16'h6971, 2'b11, 1'b1);
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (m_if.tvalid) break;
      lat++;
    end
    chk("code_latency", 9'(lat), 9'd3);
    drain("basic");

    bq.delete(); bq.push_back(16'h0011); send_frame(bq); drain("tail");
    bq.delete(); bq.push_back(16'h0000); send_frame(bq); drain("zeros");
    bq.delete(); bq.push_back(16'h3300); bq.push_back(16'h0044); send_frame(bq); drain("mixed");

    bq.delete(); repeat (127) bq.push_back(16'h0201);
    send_frame(bq); drain("max254");
    bq.delete(); repeat (128) bq.push_back(16'h0201);
    send_frame(bq); drain("over254");

    rdy_mode = 2;
    bq.delete(); bq.push_back(16'h6971); send_frame(bq); drain("backpressure");
    rdy_mode = 1;

`ifdef COBS_ENC_TKEEP_EN
    exp_q.push_back(9'h002); exp_q.push_back(9'h055); exp_q.push_back(9'h100);
    send_beat(16'hAA55, 2'b01, 1'b1); drain("keep_partial");
    exp_q.push_back(9'h001); exp_q.push_back(9'h100);
    send_beat(16'h0000, 2'b00, 1'b1); drain("keep_empty");
    exp_q.push_back(9'h003); exp_q.push_back(9'h011); exp_q.push_back(9'h022); exp_q.push_back(9'h100);
    send_beat(16'h2211, 2'b11, 1'b0);
    send_beat(16'h0000, 2'b00, 1'b1); drain("keep_close");
`else
    exp_q.push_back(9'h003); exp_q.push_back(9'h055); exp_q.push_back(9'h0AA); exp_q.push_back(9'h100);
    send_beat(16'hAA55, 2'b01, 1'b1); drain("keep_ignored");
`endif

    // reset while emitting data bytes
    mon_en = 1'b0;
    send_beat(16'h2211, 2'b11, 1'b1);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (m_if.tvalid && m_if.tdata == 8'h11) break;
      n++;
    end
    chk("reach_emit_data", 9'(m_if.tdata), 9'h011);
    rst = 1'b0;
    #1;
    chk("midrst_tvalid", 9'(m_if.tvalid), 9'h0);
    chk("midrst_tready", 9'(s_if.tready), 9'h0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    bq.delete(); bq.push_back(16'h6971); send_frame(bq); drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
